pc_sequencer: RTL and testbench

- Fetch-side controller that owns the program counter and sequences instruction fetch.
- Issues one outstanding request at a time to instruction memory (req/ack) and presents each fetched PC to decode on a valid/ready handshake.
- Handles stall back-pressure and branch/jump redirects, including discarding a stale in-flight fetch.
- Sits between the PC/next-PC logic and the instruction memory port.

---
 rtl/pc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Fetch-side controller that owns the program counter and sequences
// instruction fetch. It keeps at most one request outstanding to instruction
// memory (req/ack) and hands each fetched PC to decode over a valid/ready
// handshake. Branch/jump redirects replace the PC at once. A fetch that is
// already in flight when a redirect arrives is allowed to complete and is then
// discarded, so decode never sees a stale PC.
//
// Optional feature (compile-time macro PC_SEQ_ALIGN_CHECK_EN):
//   When defined, the block adds the output align_err. A redirect whose target
//   is not word aligned is ignored, and align_err pulses high for one cycle.
//   When undefined, every redirect target is accepted verbatim.
//
// Ports:
//   clk              in   system clock, all state changes on posedge
//   reset            in   synchronous, active-high reset
//   imem_req         out  fetch request, held with imem_addr stable until ack
//   imem_addr        out  fetch address [WIDTH]
//   imem_ack         in   memory completes the current request this cycle
//   fetch_valid      out  fetch_pc holds a fetched, non-stale PC
//   fetch_pc         out  PC of the presented fetch [WIDTH]
//   fetch_ready      in   decode accepts fetch_pc this cycle
//   redirect_valid   in   one-cycle redirect pulse
//   redirect_target  in   new PC on redirect [WIDTH]
//   align_err        out  (PC_SEQ_ALIGN_CHECK_EN only) misaligned redirect seen
//   pc               out  current architectural fetch PC [WIDTH]
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      INC      = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    input  logic             fetch_ready,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
`ifdef PC_SEQ_ALIGN_CHECK_EN
    output logic             align_err,
`endif
    output logic [WIDTH-1:0] pc
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DEC,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] w_addr_next;
    logic             r_fetch_valid;
    logic             w_fetch_valid_next;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] w_fetch_pc_next;
    logic             w_redirect;

    // A redirect that is actually taken. With the alignment check built in,
    // a misaligned target is reported and otherwise ignored.
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic w_misaligned;
    logic r_align_err;

    assign w_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign w_redirect   = redirect_valid && !w_misaligned;
    assign align_err    = r_align_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_misaligned;
        end
    end
`else
    assign w_redirect = redirect_valid;
`endif

    // -------------------------------------------------------------------------
    // Next-state / next-data logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_valid_next = r_fetch_valid;
        w_fetch_pc_next    = r_fetch_pc;

        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                if (w_redirect) begin
                    // An ack in the same cycle belongs to the old address and
                    // is discarded. Without one, the request must still run to
                    // completion before the new address can go out.
                    w_state_next = imem_ack ? S_REQ : S_DRAIN;
                end else if (imem_ack) begin
                    w_fetch_pc_next    = r_pc;
                    w_fetch_valid_next = 1'b1;
                    w_pc_next          = r_pc + INC_W;
                    w_state_next       = S_WAIT_DEC;
                end
            end
            S_WAIT_DEC: begin
                if (w_redirect) begin
                    w_state_next = S_REQ;
                end else if (r_fetch_valid && fetch_ready) begin
                    w_fetch_valid_next = 1'b0;
                    w_state_next       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Redirect has priority over everything else in the same cycle. A held
        // fetch is dropped even if decode is ready to accept it right now.
        if (w_redirect) begin
            w_pc_next          = redirect_target;
            w_fetch_valid_next = 1'b0;
        end
    end

    // The address register is loaded only on the way into REQ. It therefore
    // equals pc throughout REQ and keeps the old address throughout DRAIN.
    always_comb begin
        w_addr_next = r_addr;
        if (w_state_next == S_REQ) begin
            w_addr_next = w_pc_next;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and the result does not depend on block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_addr        <= w_addr_next;
            r_fetch_valid <= w_fetch_valid_next;
            r_fetch_pc    <= w_fetch_pc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req    = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign imem_addr   = r_addr;
    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_fetch_pc;
    assign pc          = r_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. Two instances share all inputs: u_dut
// resets to 0 and u_dut_wrap resets to 32'hFFFF_FFFC, which exercises PC wrap.
// Directed scenarios are followed by a randomized run that is scored against
// a stream-level model: each accepted fetch is the previous one plus 4, and a
// taken redirect restarts the stream at its target.
// Define PC_SEQ_ALIGN_CHECK_EN to build the bench for the alignment-check build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        fetch_valid, fetch_valid2;
    logic [31:0] fetch_pc,  fetch_pc2;
    logic [31:0] pc,        pc2;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        align_err, align_err2;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .INC(4)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .pc(pc)
    );

    pc_sequencer #(.WIDTH(32), .RESET_PC(WRAP_PC), .INC(4)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack),
        .fetch_valid(fetch_valid2), .fetch_pc(fetch_pc2), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .align_err(align_err2),
`endif
        .pc(pc2)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          auto_ack;
    int          req_cycles;
    int          valid_cycles;
    logic [31:0] acc_q[$];
    logic [31:0] req_q[$];

    // Redirect rule from the block's contract: taken unless the alignment
    // check is built in and the target is misaligned.
    function automatic bit redirect_taken();
`ifdef PC_SEQ_ALIGN_CHECK_EN
        return redirect_valid && (redirect_target[1:0] == 2'b00);
`else
        return redirect_valid;
`endif
    endfunction

    // One clock. With auto_ack, memory answers in the second cycle of each
    // request. The task records accepted fetches and each new request address.
    task automatic step();
        logic pre_req, pre_ack;
        if (auto_ack) imem_ack = imem_req && (req_cycles >= 1);
        pre_req = imem_req;
        pre_ack = imem_ack;
        if (!reset && fetch_valid && fetch_ready && !redirect_taken()) acc_q.push_back(fetch_pc);
        @(posedge clk);
        #1;
        if (reset || pre_ack || !pre_req) req_cycles = 0;
        else req_cycles++;
        if (imem_req && (!pre_req || pre_ack)) req_q.push_back(imem_addr);
        if (fetch_valid) valid_cycles++;
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        step(); step();
        reset = 1'b0;
        acc_q.delete(); req_q.delete(); valid_cycles = 0; req_cycles = 0;
    endtask

    task automatic test_reset();
        auto_ack = 1'b0; fetch_ready = 1'b1;
        do_reset();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
        n_checks++; if (fetch_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fetch_pc: got %h want 0", fetch_pc); end
        n_checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got pc=%h addr=%h want 0", pc, imem_addr); end
        n_checks++; if (pc2 !== WRAP_PC || imem_addr2 !== WRAP_PC) begin n_fail++; $display("FAIL reset_pc_wrap: got pc=%h addr=%h want %h", pc2, imem_addr2, WRAP_PC); end
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset(); auto_ack = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 40 && acc_q.size() < 4; i++) step();
        n_checks++;
        if (acc_q.size() != 4) begin
            n_fail++; $display("FAIL seq_timeout: got %0d fetches want 4", acc_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (req_q[k] !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", k, req_q[k], k * 4); end
                n_checks++; if (acc_q[k] !== 32'(k * 4)) begin n_fail++; $display("FAIL seq_fetch[%0d]: got %h want %h", k, acc_q[k], k * 4); end
            end
        end
        n_checks++; if (valid_cycles != 4) begin n_fail++; $display("FAIL seq_valid_len: got %0d want 4", valid_cycles); end
    endtask

    task automatic test_stall();
        do_reset(); auto_ack = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 40 && !(fetch_valid && fetch_pc == 32'h8); i++) step();
        n_checks++; if (!(fetch_valid && fetch_pc == 32'h8)) begin n_fail++; $display("FAIL stall_reach: got valid=%b pc=%h want 1/8", fetch_valid, fetch_pc); end
        fetch_ready = 1'b0; req_q.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b pc=%h req=%b want 1/8/0", i, fetch_valid, fetch_pc, imem_req);
            end
        end
        fetch_ready = 1'b1; acc_q.delete();
        for (int i = 0; i < 10 && req_q.size() == 0; i++) step();
        n_checks++; if (acc_q.size() != 1 || acc_q[0] !== 32'h8) begin n_fail++; $display("FAIL stall_accept: got n=%0d pc=%h want 1/8", acc_q.size(), acc_q[0]); end
        n_checks++; if (req_q.size() == 0 || req_q[0] !== 32'hC) begin n_fail++; $display("FAIL stall_next_req: got %h want c", req_q[0]); end
    endtask

    task automatic test_redirect_drain();
        do_reset(); auto_ack = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 60 && !(imem_req && imem_addr == 32'h10); i++) step();
        auto_ack = 1'b0; imem_ack = 1'b0; acc_q.delete();
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc !== 32'h100 || fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_enter: got req=%b addr=%h pc=%h valid=%b want 1/10/100/0", imem_req, imem_addr, pc, fetch_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10 || fetch_valid !== 1'b0) begin
                n_fail++; $display("FAIL drain_hold[%0d]: got req=%b addr=%h valid=%b want 1/10/0", i, imem_req, imem_addr, fetch_valid);
            end
        end
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_exit: got req=%b addr=%h valid=%b want 1/100/0", imem_req, imem_addr, fetch_valid);
        end
        auto_ack = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) step();
        n_checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin n_fail++; $display("FAIL drain_fetch: got %h want 100", acc_q[0]); end
    endtask

    task automatic test_redirect_ack();
        do_reset(); auto_ack = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 80 && !(imem_req && imem_addr == 32'h20 && req_cycles >= 1); i++) step();
        acc_q.delete();
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (fetch_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || pc !== 32'h200) begin
            n_fail++; $display("FAIL redir_ack: got valid=%b req=%b addr=%h pc=%h want 0/1/200/200", fetch_valid, imem_req, imem_addr, pc);
        end
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) step();
        n_checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h200) begin n_fail++; $display("FAIL redir_ack_fetch: got %h want 200", acc_q[0]); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset(); auto_ack = 1'b1; fetch_ready = 1'b1;
        for (int i = 0; i < 20 && !fetch_valid2; i++) step();
        n_checks++; if (fetch_valid2 !== 1'b1 || fetch_pc2 !== WRAP_PC) begin n_fail++; $display("FAIL wrap_fetch: got valid=%b pc=%h want 1/%h", fetch_valid2, fetch_pc2, WRAP_PC); end
        step();
        n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0 || pc2 !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h pc=%h want 1/0/0", imem_req2, imem_addr2, pc2); end
        auto_ack = 1'b0; imem_ack = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_drain: got req=%b addr=%h want 1/0", imem_req2, imem_addr2); end
        reset = 1'b1; step(); reset = 1'b0;
        n_checks++;
        if (pc2 !== WRAP_PC || imem_req2 !== 1'b0 || fetch_valid2 !== 1'b0 || imem_addr2 !== WRAP_PC) begin
            n_fail++; $display("FAIL drain_reset: got pc=%h req=%b valid=%b addr=%h want %h/0/0/%h", pc2, imem_req2, fetch_valid2, imem_addr2, WRAP_PC, WRAP_PC);
        end
        n_checks++; if (pc !== 32'h0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL drain_reset0: got pc=%h req=%b want 0/0", pc, imem_req); end
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin
            n_fail++; $display("FAIL late_ack: got req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, fetch_valid);
        end
    endtask

    task automatic test_misaligned_redirect();
        logic [31:0] f, p;
        do_reset(); auto_ack = 1'b1; fetch_ready = 1'b0;
        for (int i = 0; i < 20 && !fetch_valid; i++) step();
        f = fetch_pc; p = pc;
        acc_q.delete();
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        n_checks++;
        if (align_err !== 1'b1 || fetch_valid !== 1'b1 || fetch_pc !== f || pc !== p) begin
            n_fail++; $display("FAIL align_pulse: got err=%b valid=%b fpc=%h pc=%h want 1/1/%h/%h", align_err, fetch_valid, fetch_pc, pc, f, p);
        end
        step();
        n_checks++; if (align_err !== 1'b0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL align_clear: got err=%b valid=%b want 0/1", align_err, fetch_valid); end
        fetch_ready = 1'b1; step();
        n_checks++; if (acc_q.size() != 1 || acc_q[0] !== f) begin n_fail++; $display("FAIL align_accept: got n=%0d pc=%h want 1/%h", acc_q.size(), acc_q[0], f); end
`else
        n_checks++; if (pc !== 32'h102 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL odd_redirect: got pc=%h valid=%b want 102/0 (held %h)", pc, fetch_valid, f); end
        fetch_ready = 1'b1;
        for (int i = 0; i < 20 && acc_q.size() == 0; i++) step();
        n_checks++; if (acc_q.size() == 0 || acc_q[0] !== 32'h102) begin n_fail++; $display("FAIL odd_fetch: got %h want 102", acc_q[0]); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_next, tgt, p_addr, p_fpc;
        logic        p_req, p_ack, p_valid, p_ready, taken, mis;
        int          n_acc;
        do_reset(); auto_ack = 1'b0;
        exp_next = 32'h0; n_acc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fetch_ready    = ($urandom_range(0, 3) != 0);
            imem_ack       = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            redirect_target = tgt;
            taken   = redirect_taken();
            mis     = redirect_valid && (tgt[1:0] != 2'b00);
            p_req   = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_valid = fetch_valid; p_fpc = fetch_pc; p_ready = fetch_ready;
            if (p_valid && p_ready && !taken) begin
                n_acc++;
                n_checks++; if (p_fpc !== exp_next) begin n_fail++; $display("FAIL rnd_fetch@%0d: got %h want %h", cyc, p_fpc, exp_next); end
                exp_next = exp_next + 32'd4;
            end
            if (taken) exp_next = tgt;
            step();
            if (taken) begin
                n_checks++; if (pc !== tgt || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect@%0d: got pc=%h valid=%b want %h/0", cyc, pc, fetch_valid, tgt); end
            end
            if (p_req && !p_ack) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== p_addr) begin n_fail++; $display("FAIL rnd_req_hold@%0d: got req=%b addr=%h want 1/%h", cyc, imem_req, imem_addr, p_addr); end
            end
            if (p_valid && !p_ready && !taken) begin
                n_checks++; if (fetch_valid !== 1'b1 || fetch_pc !== p_fpc) begin n_fail++; $display("FAIL rnd_valid_hold@%0d: got valid=%b pc=%h want 1/%h", cyc, fetch_valid, fetch_pc, p_fpc); end
            end
`ifdef PC_SEQ_ALIGN_CHECK_EN
            n_checks++; if (align_err !== mis) begin n_fail++; $display("FAIL rnd_align@%0d: got %b want %b", cyc, align_err, mis); end
`else
            if (mis && pc !== tgt) begin n_checks++; n_fail++; $display("FAIL rnd_odd@%0d: got pc=%h want %h", cyc, pc, tgt); end
`endif
        end
        redirect_valid = 1'b0; imem_ack = 1'b0;
        n_checks++; if (n_acc < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d accepts want >=100", n_acc); end
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; fetch_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        auto_ack = 1'b0; req_cycles = 0; valid_cycles = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap_and_reset();
        test_misaligned_redirect();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
